// File: rtl/rv_test_monitor.sv
// End-of-test monitor for RV32 regressions: detects completion by PC sentinel and/or
// tohost store, and latches a pass/fail/timeout verdict with test number and cycle count.
module rv_test_monitor #(
   parameter int              XLEN        = 32,
   parameter int              MODE        = 0,
   parameter logic [XLEN-1:0] PASS_PC     = 'h44,
   parameter int              HOLD        = 1,
   parameter logic [XLEN-1:0] TOHOST_ADDR = 'h1000,
   parameter int              TIMEOUT     = 5000,
   parameter int              CNT_W       = $clog2(TIMEOUT + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             ret_valid,
   input  logic [XLEN-1:0]  ret_pc,
   input  logic [XLEN-1:0]  gp,
   input  logic             st_valid,
   input  logic [XLEN-1:0]  st_addr,
   input  logic [XLEN-1:0]  st_data,
   output logic             done,
   output logic             done_pulse,
   output logic             pass,
   output logic             fail,
   output logic             timeout,
   output logic [XLEN-2:0]  test_num,
   output logic [CNT_W-1:0] cycles
);

   typedef enum logic {ST_RUN, ST_DONE} state_t;

   localparam logic             SENT_EN   = (MODE != 1);
   localparam logic             TOHOST_EN = (MODE != 0);
   localparam logic [3:0]       HOLD_LAST = 4'(HOLD - 1);
   localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CYC_MAX   = CNT_W'(TIMEOUT);

   state_t           state;
   logic [3:0]       hold_cnt;
   logic             pc_match;
   logic             sent_hit;
   logic             tohost_hit;
   logic             event_hit;
   logic [XLEN-1:0]  report;
   logic [CNT_W-1:0] cycles_next;

   always_comb begin
      pc_match    = ret_valid && (ret_pc == PASS_PC);
      sent_hit    = SENT_EN && pc_match && (hold_cnt == HOLD_LAST);
      tohost_hit  = TOHOST_EN && st_valid && (st_addr == TOHOST_ADDR) && st_data[0];
      event_hit   = sent_hit || tohost_hit;
      // tohost wins when both completion sources fire in the same cycle
      report      = tohost_hit ? st_data : gp;
      cycles_next = (cycles == CYC_MAX) ? cycles : cycles + CNT_W'(1);
   end

   // NOTE: all state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_RUN;
         hold_cnt   <= '0;
         cycles     <= '0;
         done       <= 1'b0;
         done_pulse <= 1'b0;
         pass       <= 1'b0;
         fail       <= 1'b0;
         timeout    <= 1'b0;
         test_num   <= '0;
      end else if (clr) begin
         state      <= ST_RUN;
         hold_cnt   <= '0;
         cycles     <= '0;
         done       <= 1'b0;
         done_pulse <= 1'b0;
         pass       <= 1'b0;
         fail       <= 1'b0;
         timeout    <= 1'b0;
         test_num   <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               cycles <= cycles_next;
               // idle cycles leave the hold count alone; only a foreign retire breaks it
               if (pc_match) begin
                  if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 4'd1;
               end else if (ret_valid) begin
                  hold_cnt <= '0;
               end
               if (event_hit) begin
                  state      <= ST_DONE;
                  done       <= 1'b1;
                  done_pulse <= 1'b1;
                  pass       <= (report == XLEN'(1));
                  fail       <= (report != XLEN'(1));
                  test_num   <= report[XLEN-1:1];
               end else if (cycles == CYC_LAST) begin
                  state      <= ST_DONE;
                  done       <= 1'b1;
                  done_pulse <= 1'b1;
                  timeout    <= 1'b1;
               end
            end
            default: done_pulse <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_rv_test_monitor.sv
// Self-checking bench for rv_test_monitor: five configurations share one stimulus trace,
// and each is compared against a trace-scanning reference model.
module tb_rv_test_monitor;

   localparam int NI = 5;
   localparam int MODES [NI] = '{0, 0, 1, 2, 0};
   localparam int HOLDS [NI] = '{1, 3, 1, 2, 1};
   localparam int TMOS  [NI] = '{5000, 5000, 5000, 5000, 50};

   typedef struct packed {
      logic        done;
      logic        pass;
      logic        fail;
      logic        to;
      logic [30:0] tn;
      int          cyc;
      int          dedge;
      int          pulses;
   } res_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr = 1'b0;
   logic        ret_valid = 1'b0;
   logic        st_valid = 1'b0;
   logic [31:0] ret_pc = '0;
   logic [31:0] gp = '0;
   logic [31:0] st_addr = '0;
   logic [31:0] st_data = '0;

   logic        done_w  [NI];
   logic        pulse_w [NI];
   logic        pass_w  [NI];
   logic        fail_w  [NI];
   logic        to_w    [NI];
   logic [30:0] tn_w    [NI];
   logic [12:0] cyc_w   [4];
   logic [5:0]  cyc4;

   logic        a_rv [256];
   logic [31:0] a_pc [256];
   logic [31:0] a_gp [256];
   logic        a_sv [256];
   logic [31:0] a_sa [256];
   logic [31:0] a_sd [256];

   res_t obs [NI];
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      rv_test_monitor #(.MODE(MODES[g]), .HOLD(HOLDS[g]), .TIMEOUT(TMOS[g])) u_dut (
         .clk(clk), .rst(rst), .clr(clr),
         .ret_valid(ret_valid), .ret_pc(ret_pc), .gp(gp),
         .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
         .done(done_w[g]), .done_pulse(pulse_w[g]), .pass(pass_w[g]), .fail(fail_w[g]),
         .timeout(to_w[g]), .test_num(tn_w[g]), .cycles(cyc_w[g])
      );
   end

   rv_test_monitor #(.MODE(MODES[4]), .HOLD(HOLDS[4]), .TIMEOUT(TMOS[4])) u_to (
      .clk(clk), .rst(rst), .clr(clr),
      .ret_valid(ret_valid), .ret_pc(ret_pc), .gp(gp),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
      .done(done_w[4]), .done_pulse(pulse_w[4]), .pass(pass_w[4]), .fail(fail_w[4]),
      .timeout(to_w[4]), .test_num(tn_w[4]), .cycles(cyc4)
   );

   // Scans the trace edge by edge: first completion event or budget expiry decides everything.
   function automatic res_t model(input int mode, input int hold, input int tmo, input int n);
      res_t        r;
      int          run;
      logic        sent;
      logic        th;
      logic [31:0] rep;
      r   = '0;
      run = 0;
      for (int e = 1; e <= n; e++) begin
         int k = e - 1;
         sent = 1'b0;
         if (a_rv[k]) begin
            if (a_pc[k] == 32'h44) begin
               run++;
               sent = (mode != 1) && (run >= hold);
            end else begin
               run = 0;
            end
         end
         th = (mode != 0) && a_sv[k] && (a_sa[k] == 32'h1000) && a_sd[k][0];
         if (sent || th) begin
            rep      = th ? a_sd[k] : a_gp[k];
            r.done   = 1'b1;
            r.pass   = (rep == 32'd1);
            r.fail   = (rep != 32'd1);
            r.tn     = (rep == 32'd1) ? 31'd0 : rep[31:1];
            r.cyc    = e;
            r.dedge  = e;
            r.pulses = 1;
            return r;
         end
         if (e == tmo) begin
            r.done   = 1'b1;
            r.to     = 1'b1;
            r.cyc    = e;
            r.dedge  = e;
            r.pulses = 1;
            return r;
         end
      end
      r.cyc = n;
      return r;
   endfunction

   function automatic res_t cur(input int i);
      res_t x;
      x        = '0;
      x.done   = done_w[i];
      x.pass   = pass_w[i];
      x.fail   = fail_w[i];
      x.to     = to_w[i];
      x.tn     = tn_w[i];
      x.cyc    = (i == 4) ? int'(cyc4) : int'(cyc_w[i[1:0]]);
      x.pulses = int'(pulse_w[i]);
      return x;
   endfunction

   function automatic string fmt(input res_t x);
      return $sformatf("done=%b pass=%b fail=%b to=%b tn=%0d cyc=%0d edge=%0d pulses=%0d",
                       x.done, x.pass, x.fail, x.to, x.tn, x.cyc, x.dedge, x.pulses);
   endfunction

   task automatic idle_inputs();
      ret_valid = 1'b0; ret_pc = '0; gp = '0;
      st_valid = 1'b0; st_addr = '0; st_data = '0;
   endtask

   task automatic clear_trace();
      for (int k = 0; k < 256; k++) begin
         a_rv[k] = 1'b0; a_pc[k] = '0; a_gp[k] = '0;
         a_sv[k] = 1'b0; a_sa[k] = '0; a_sd[k] = '0;
      end
   endtask

   // Resets all DUTs, plays trace cycles 0..n-1 onto edges 1..n, records observed results.
   task automatic run_trace(input int n);
      int   cnt [NI];
      int   first [NI];
      res_t x;
      clr = 1'b0;
      idle_inputs();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      for (int i = 0; i < NI; i++) begin cnt[i] = 0; first[i] = 0; end
      for (int k = 0; k < n; k++) begin
         ret_valid = a_rv[k]; ret_pc = a_pc[k]; gp = a_gp[k];
         st_valid = a_sv[k]; st_addr = a_sa[k]; st_data = a_sd[k];
         @(posedge clk);
         #1;
         for (int i = 0; i < NI; i++) begin
            if (pulse_w[i]) begin
               cnt[i]++;
               if (first[i] == 0) first[i] = k + 1;
            end
         end
      end
      idle_inputs();
      for (int i = 0; i < NI; i++) begin
         x        = cur(i);
         x.pulses = cnt[i];
         x.dedge  = first[i];
         obs[i]   = x;
      end
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) begin
         n_tests++;
         if (cur(i) !== res_t'('0)) begin
            n_fail++;
            $display("FAIL reset inst%0d got {%s} want all zero", i, fmt(cur(i)));
         end
      end
   endtask

   task automatic test_pass_sentinel();
      res_t c, e;
      clear_trace();
      for (int k = 0; k < 60; k++) begin
         a_rv[k] = 1'b1; a_pc[k] = 32'h100 + 32'(4 * k); a_gp[k] = 32'd1;
      end
      a_pc[39] = 32'h44;
      run_trace(60);
      c = '0; c.done = 1'b1; c.pass = 1'b1; c.cyc = 40; c.dedge = 40; c.pulses = 1;
      n_tests++;
      if (obs[0] !== c) begin
         n_fail++;
         $display("FAIL pass_sentinel_const got {%s} want {%s}", fmt(obs[0]), fmt(c));
      end
      for (int i = 0; i < NI; i++) begin
         e = model(MODES[i], HOLDS[i], TMOS[i], 60);
         n_tests++;
         if (obs[i] !== e) begin
            n_fail++;
            $display("FAIL pass_sentinel inst%0d got {%s} want {%s}", i, fmt(obs[i]), fmt(e));
         end
      end
   endtask

   task automatic test_fail_sentinel();
      res_t c, e;
      clear_trace();
      for (int k = 0; k < 20; k++) begin
         a_rv[k] = 1'b1; a_pc[k] = 32'h200; a_gp[k] = 32'h0B;
      end
      a_pc[9] = 32'h44;
      run_trace(20);
      c = '0; c.done = 1'b1; c.fail = 1'b1; c.tn = 31'd5; c.cyc = 10; c.dedge = 10; c.pulses = 1;
      n_tests++;
      if (obs[0] !== c) begin
         n_fail++;
         $display("FAIL fail_sentinel_const got {%s} want {%s}", fmt(obs[0]), fmt(c));
      end
      for (int i = 0; i < NI; i++) begin
         e = model(MODES[i], HOLDS[i], TMOS[i], 20);
         n_tests++;
         if (obs[i] !== e) begin
            n_fail++;
            $display("FAIL fail_sentinel inst%0d got {%s} want {%s}", i, fmt(obs[i]), fmt(e));
         end
      end
   endtask

   task automatic test_hold();
      res_t c, e;
      int   seq_k [6] = '{2, 4, 5, 6, 9, 11};
      clear_trace();
      for (int j = 0; j < 6; j++) begin
         a_rv[seq_k[j]] = 1'b1;
         a_pc[seq_k[j]] = (j == 2) ? 32'h48 : 32'h44;
      end
      for (int k = 0; k < 20; k++) a_gp[k] = 32'd1;
      run_trace(20);
      c = '0; c.done = 1'b1; c.pass = 1'b1; c.cyc = 12; c.dedge = 12; c.pulses = 1;
      n_tests++;
      if (obs[1] !== c) begin
         n_fail++;
         $display("FAIL hold3_const got {%s} want {%s}", fmt(obs[1]), fmt(c));
      end
      for (int i = 0; i < NI; i++) begin
         e = model(MODES[i], HOLDS[i], TMOS[i], 20);
         n_tests++;
         if (obs[i] !== e) begin
            n_fail++;
            $display("FAIL hold inst%0d got {%s} want {%s}", i, fmt(obs[i]), fmt(e));
         end
      end
   endtask

   task automatic test_tohost();
      res_t c, e;
      clear_trace();
      a_sv[3]  = 1'b1; a_sa[3]  = 32'h1000; a_sd[3]  = 32'h0;
      a_sv[5]  = 1'b1; a_sa[5]  = 32'h1000; a_sd[5]  = 32'h2;
      a_sv[8]  = 1'b1; a_sa[8]  = 32'h1004; a_sd[8]  = 32'h7;
      a_sv[12] = 1'b1; a_sa[12] = 32'h1000; a_sd[12] = 32'h1;
      run_trace(20);
      c = '0; c.done = 1'b1; c.pass = 1'b1; c.cyc = 13; c.dedge = 13; c.pulses = 1;
      n_tests++;
      if (obs[2] !== c) begin
         n_fail++;
         $display("FAIL tohost_const got {%s} want {%s}", fmt(obs[2]), fmt(c));
      end
      for (int i = 0; i < NI; i++) begin
         e = model(MODES[i], HOLDS[i], TMOS[i], 20);
         n_tests++;
         if (obs[i] !== e) begin
            n_fail++;
            $display("FAIL tohost inst%0d got {%s} want {%s}", i, fmt(obs[i]), fmt(e));
         end
      end
   endtask

   task automatic test_simultaneous();
      res_t c, e;
      clear_trace();
      a_rv[3] = 1'b1; a_pc[3] = 32'h44; a_gp[3] = 32'd1;
      a_rv[6] = 1'b1; a_pc[6] = 32'h44; a_gp[6] = 32'd1;
      a_sv[6] = 1'b1; a_sa[6] = 32'h1000; a_sd[6] = 32'h9;
      run_trace(15);
      c = '0; c.done = 1'b1; c.fail = 1'b1; c.tn = 31'd4; c.cyc = 7; c.dedge = 7; c.pulses = 1;
      n_tests++;
      if (obs[3] !== c) begin
         n_fail++;
         $display("FAIL simultaneous_const got {%s} want {%s}", fmt(obs[3]), fmt(c));
      end
      for (int i = 0; i < NI; i++) begin
         e = model(MODES[i], HOLDS[i], TMOS[i], 15);
         n_tests++;
         if (obs[i] !== e) begin
            n_fail++;
            $display("FAIL simultaneous inst%0d got {%s} want {%s}", i, fmt(obs[i]), fmt(e));
         end
      end
   endtask

   task automatic test_timeout_clr();
      res_t c, x;
      clear_trace();
      run_trace(60);
      c = '0; c.done = 1'b1; c.to = 1'b1; c.cyc = 50; c.dedge = 50; c.pulses = 1;
      n_tests++;
      if (obs[4] !== c) begin
         n_fail++;
         $display("FAIL timeout got {%s} want {%s}", fmt(obs[4]), fmt(c));
      end
      clr = 1'b1;
      @(posedge clk);
      #1 clr = 1'b0;
      for (int i = 0; i < NI; i += 4) begin
         n_tests++;
         if (cur(i) !== res_t'('0)) begin
            n_fail++;
            $display("FAIL clr inst%0d got {%s} want all zero", i, fmt(cur(i)));
         end
      end
      @(posedge clk);
      #1;
      c = '0; c.cyc = 1;
      x = cur(4);
      n_tests++;
      if (x !== c) begin
         n_fail++;
         $display("FAIL clr_restart got {%s} want {%s}", fmt(x), fmt(c));
      end
      repeat (4) @(posedge clk);
      #4 rst = 1'b0;
      #1;
      for (int i = 0; i < NI; i += 4) begin
         n_tests++;
         if (cur(i) !== res_t'('0)) begin
            n_fail++;
            $display("FAIL async_reset_run inst%0d got {%s} want all zero", i, fmt(cur(i)));
         end
      end
   endtask

   task automatic test_async_done();
      res_t e;
      clear_trace();
      a_rv[4] = 1'b1; a_pc[4] = 32'h44; a_gp[4] = 32'd3;
      run_trace(10);
      e = model(MODES[0], HOLDS[0], TMOS[0], 10);
      n_tests++;
      if (obs[0] !== e) begin
         n_fail++;
         $display("FAIL async_done_pre got {%s} want {%s}", fmt(obs[0]), fmt(e));
      end
      #3 rst = 1'b0;
      #1;
      n_tests++;
      if (cur(0) !== res_t'('0)) begin
         n_fail++;
         $display("FAIL async_reset_done got {%s} want all zero", fmt(cur(0)));
      end
   endtask

   task automatic test_random();
      res_t e;
      int   n, dens;
      for (int it = 0; it < 40; it++) begin
         clear_trace();
         n    = $urandom_range(120, 30);
         dens = (it % 4 == 0) ? 0 : int'($urandom_range(3, 1));
         for (int k = 0; k < n; k++) begin
            int r = $urandom_range(9, 0);
            a_rv[k] = ($urandom_range(9, 0) < 7);
            a_pc[k] = (r < dens) ? 32'h44 : ((r < 6) ? 32'h48 : ($urandom & 32'hFFFF_FFF0) | 32'h100);
            a_gp[k] = $urandom_range(1, 0) ? 32'd1 : 32'($urandom_range(40, 0));
            a_sv[k] = (dens != 0) && ($urandom_range(9, 0) < 2);
            a_sa[k] = $urandom_range(1, 0) ? 32'h1000 : 32'h1004;
            a_sd[k] = ($urandom_range(2, 0) == 0) ? 32'd1 : 32'($urandom_range(200, 0));
         end
         run_trace(n);
         for (int i = 0; i < NI; i++) begin
            e = model(MODES[i], HOLDS[i], TMOS[i], n);
            n_tests++;
            if (obs[i] !== e) begin
               n_fail++;
               $display("FAIL random it%0d inst%0d got {%s} want {%s}", it, i, fmt(obs[i]), fmt(e));
            end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired before the bench completed");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_pass_sentinel();
      test_fail_sentinel();
      test_hold();
      test_tohost();
      test_simultaneous();
      test_timeout_clr();
      test_async_done();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rv_test_monitor.md
# rv_test_monitor

Synthesizable end-of-test monitor for the RV32 core regression flow. It replaces the ad-hoc pass/fail check in each per-test bench with one parametrised block. The block snoops the core's retire PC, the `gp` (x3) value and data-store traffic, and detects test completion by a PC sentinel, a `tohost` store, or both. It latches a pass/fail/timeout verdict together with the failing test number and the cycle count.

## Interface
Parameters:
- `XLEN`, 32, datapath width of PC, `gp` and store buses.
- `MODE`, 0, completion source: 0 = PC sentinel, 1 = `tohost` store, 2 = whichever comes first.
- `PASS_PC`, 32'h44, sentinel PC value.
- `HOLD`, 1, number of consecutive valid retires at `PASS_PC` needed for a sentinel event (1..15).
- `TOHOST_ADDR`, 32'h1000, `tohost` word address.
- `TIMEOUT`, 5000, cycle budget before a timeout verdict (≥1).
- `CNT_W`, $clog2(TIMEOUT+1), cycle counter width.

Ports:
- `clk` in 1: clock. All flops update on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous restart. Returns the block to RUN with all outputs cleared.
- `ret_valid` in 1: one instruction retires this cycle.
- `ret_pc` in XLEN: PC of the retiring instruction.
- `gp` in XLEN: current x3 value.
- `st_valid` in 1: a data store is issued this cycle.
- `st_addr` in XLEN: store address.
- `st_data` in XLEN: store data.
- `done` out 1: verdict latched (level).
- `done_pulse` out 1: single-cycle strobe on entry to DONE.
- `pass` out 1: test passed.
- `fail` out 1: test reported failure.
- `timeout` out 1: budget expired with no completion event.
- `test_num` out XLEN-1: failing test number (report value >> 1), 0 on pass or timeout.
- `cycles` out CNT_W: cycles spent in RUN up to the verdict.

## Operation
- FSM has two states, RUN and DONE. Reset and `clr` both enter RUN.
- **RUN**
  - `cycles` increments every cycle and saturates at TIMEOUT.
  - The hold counter counts consecutive `ret_valid` cycles with `ret_pc==PASS_PC`.
  - A `ret_valid` with any other PC zeroes the hold counter. Cycles with `ret_valid=0` leave it unchanged.
- **Sentinel event** (MODE 0/2): `ret_valid && ret_pc==PASS_PC && hold_cnt==HOLD-1`.
  - The report value is `gp`.
- **tohost event** (MODE 1/2): `st_valid && st_addr==TOHOST_ADDR && st_data[0]==1`.
  - The report value is `st_data`.
  - A matching store with `st_data[0]==0` is ignored.
- **Simultaneous events in MODE 2**: the tohost event wins.
- **Verdict from a report value `r`**:
  - `r==1`: `pass=1`, `test_num=0`.
  - Otherwise: `fail=1`, `test_num=r[XLEN-1:1]`.
  - `r==0` counts as fail with `test_num=0`.
- **Timeout**: in RUN, when `cycles==TIMEOUT-1` and no event occurs, the block sets `timeout=1` and moves to DONE.
  - An event in that same cycle takes priority; `timeout` stays 0.
- **DONE**
  - All outputs hold their values. Events and stores are ignored.
  - Only `rst` or `clr` leaves DONE.
- **`clr` priority**: `clr` overrides any event in the same cycle.

## Timing
- **Reset values**: every output is 0, `cycles` is 0 and the hold counter is 0. The asynchronous assert takes effect immediately.
- **Reset release**: RUN starts on the first rising edge after `rst` goes high. That edge counts as `cycles=1`.
- **Latency**: an event sampled at edge N gives `done`, `done_pulse` and the verdict outputs valid after edge N.
  - `done_pulse` is high for exactly one cycle.
  - `cycles` freezes at the value it reaches on edge N, i.e. the number of RUN edges inclusive.
- **Outputs**: all outputs are registered. There is no combinational path from inputs to outputs.
- **Reset during RUN or DONE**: all state is lost and no pulse is emitted.
- **Counter width**: `cycles` is never allowed to wrap. Saturation is guaranteed because CNT_W ≥ $clog2(TIMEOUT+1).

## Test plan
- MODE 0, HOLD 1, `gp=1`, retire stream reaches PC 0x44 at edge 40 → `done=1`, `pass=1`, `test_num=0`, `cycles=40`, one `done_pulse`.
- MODE 0, `gp=0x0B` at the sentinel → `fail=1`, `test_num=5`, `pass=0`.
- MODE 0, HOLD 3, retires 0x44, 0x44, 0x48, 0x44, 0x44, 0x44 → verdict only after the sixth retire. Idle cycles between matching retires do not break the hold.
- MODE 1, store to 0x1000 with data 0x2 (ignored), then data 0x1 → `pass=1` after the second store only. A store of 0x7 to 0x1004 is ignored.
- MODE 2, sentinel with `gp=1` and tohost store data 0x9 in the same cycle → `fail=1`, `test_num=4`.
- TIMEOUT 50 with no events → `timeout=1`, `done=1`, `cycles=50`. Then:
  - Asserting `clr` for 1 cycle clears all outputs and restarts counting from 0.
  - Asserting `rst` low mid-RUN zeroes all outputs asynchronously.
